ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences an external ram_8x32 instance as a router input-port buffer for the 2x4 mesh NoC. It accepts flits on a valid/ready input and generates RAM write/read addresses and enables. Because the RAM has 1-cycle registered read latency, a 2-entry output stage presents first-word-fall-through flits on a valid/ready output. At integration the RAM's wr_clk and rd_clk are both tied to clk, and its rst_n is tied to ~rst.

---
 rtl/ram_fifo_ctrl_pkg.sv | 29 ++
 rtl/ram_fifo_ctrl_if.sv | 25 ++
 rtl/ram_out_skid.sv | 67 ++++++
 rtl/ram_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared widths, output-stage state type and helpers for the RAM-backed router FIFO.
// Widths fall back to the mesh defaults when global.v has not been read first.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RAM_FIFO_CNT_W
`define RAM_FIFO_CNT_W (`ADDR_WIDTH + 2)
`endif

package ram_fifo_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = `ADDR_WIDTH;
    localparam int unsigned DATA_W_DEF = `DATA_WIDTH;

    // Encoding equals the number of flits held in the output stage.
    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_HEAD  = 2'd1,
        OB_FULL  = 2'd2
    } ob_state_e;

    function automatic logic [1:0] ob_count(input ob_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready flit streams on the input and output side of ram_fifo_ctrl.
interface ram_fifo_ctrl_if
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/ram_out_skid.sv
// Two-entry first-word-fall-through output stage (head + skid) behind the RAM read port.
module ram_out_skid
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        ob_cnt
);

    ob_state_e         state;
    logic [DATA_W-1:0] skid;

    assign ob_cnt = ob_count(state);

    // Issue logic upstream guarantees a load never arrives while full and not popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OB_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            unique case (state)
                OB_EMPTY: begin
                    if (load) begin
                        out_data  <= load_data;
                        out_valid <= 1'b1;
                        state     <= OB_HEAD;
                    end
                end
                OB_HEAD: begin
                    if (load && pop) begin
                        out_data <= load_data;
                    end else if (load) begin
                        skid  <= load_data;
                        state <= OB_FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= OB_EMPTY;
                    end
                end
                OB_FULL: begin
                    if (pop) begin
                        out_data <= skid;
                        if (load) begin
                            skid <= load_data;
                        end else begin
                            state <= OB_HEAD;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= OB_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing an external ram_8x32 as a NoC router input buffer.
// Define RAM_FIFO_BYPASS_EN to let flits skip the RAM when the FIFO is otherwise empty.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    ram_fifo_ctrl_if.slave      fifo,
    output logic [ADDR_W+1:0]   count,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [DATA_W-1:0]   ram_wr_data,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    input  logic [DATA_W-1:0]   ram_rd_data
);

    localparam int unsigned   CNT_W   = ADDR_W + 2;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              pend;

    logic              push;
    logic              pop;
    logic              bypass;
    logic              load;
    logic              ob_room;
    logic              out_valid;
    logic [1:0]        ob_cnt;
    logic [2:0]        ob_after;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] load_data;

    assign fifo.in_ready  = !rst && (ram_cnt < DEPTH_C);
    assign fifo.out_valid = out_valid;
    assign fifo.out_data  = out_data;

    assign push = fifo.in_valid && fifo.in_ready;
    assign pop  = out_valid && fifo.out_ready;

    // Occupancy of the output stage once this cycle's pop and in-flight read have landed.
    assign ob_after = {1'b0, ob_cnt} + {2'b00, pend} - {2'b00, pop};
    assign ob_room  = ob_after < 3'd2;

`ifdef RAM_FIFO_BYPASS_EN
    assign bypass = push && (ram_cnt == '0) && !pend && ob_room;
`else
    assign bypass = 1'b0;
`endif

    assign ram_wr_en   = push && !bypass;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = fifo.in_data;

    assign ram_rd_en   = !rst && (ram_cnt != '0) && ob_room;
    assign ram_rd_addr = rd_ptr;

    assign load      = pend || bypass;
    assign load_data = pend ? ram_rd_data : fifo.in_data;

    assign count = CNT_W'(ram_cnt) + CNT_W'(pend) + CNT_W'(ob_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            pend    <= 1'b0;
        end else begin
            if (ram_wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (ram_rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            pend <= ram_rd_en;
            unique case ({ram_wr_en, ram_rd_en})
                2'b10:   ram_cnt <= ram_cnt + (ADDR_W + 1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (ADDR_W + 1)'(1);
                default: ram_cnt <= ram_cnt;
            endcase
        end
    end

    ram_out_skid #(
        .DATA_W (DATA_W)
    ) u_out_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ob_cnt    (ob_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural ram_8x32 and a queue reference model.
`timescale 1ns/1ps
module tb_ram_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 32;
`ifdef RAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
    localparam logic EXP_WR = 1'b0;
`else
    localparam int LAT = 3;
    localparam logic EXP_WR = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW+1:0] count;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] mem [8];

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int wraps    = 0;

    logic [DW-1:0] q [$];

    ram_fifo_ctrl_if #(.DATA_W(DW)) bus ();

    ram_fifo_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo        (bus),
        .count       (count),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (rst) ram_rd_data <= '0;
        else if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    // Scoreboard: occupancy equals pushes minus pops; pops must follow push order.
    initial begin
        logic          stall_prev;
        logic [DW-1:0] stall_data;
        logic [DW-1:0] exp;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                stall_prev = 1'b0;
            end else begin
                checks++;
                if (int'(count) !== q.size()) begin
                    failures++;
                    $display("FAIL count: got %0d expected %0d", count, q.size());
                end
                if (q.size() < 8) begin
                    checks++;
                    if (bus.in_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL in_ready_low: got %b expected 1 at occupancy %0d", bus.in_ready, q.size());
                    end
                end else if (q.size() == 10) begin
                    checks++;
                    if (bus.in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL in_ready_full: got %b expected 0", bus.in_ready);
                    end
                end
                if (ram_wr_en && ram_rd_en) begin
                    checks++;
                    if (ram_wr_addr == ram_rd_addr) begin
                        failures++;
                        $display("FAIL collision: wr_addr %0d equals rd_addr %0d", ram_wr_addr, ram_rd_addr);
                    end
                end
                if (stall_prev) begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== stall_data) begin
                        failures++;
                        $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                                 bus.out_valid, bus.out_data, stall_data);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL pop_empty: got data %h expected no output", bus.out_data);
                    end else begin
                        exp = q.pop_front();
                        if (bus.out_data !== exp) begin
                            failures++;
                            $display("FAIL order: got %h expected %h", bus.out_data, exp);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
                if (ram_wr_en) begin
                    wr_cnt++;
                    if (ram_wr_addr == 3'd7) wraps++;
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                stall_data = bus.out_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = $urandom;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || count !== '0 || bus.out_data !== '0) begin
            failures++;
            $display("FAIL reset_out: got valid=%b count=%0d data=%h expected 0 0 0", bus.out_valid, count, bus.out_data);
        end
        checks++;
        if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_ram: got wr_en=%b rd_en=%b expected 0 0", ram_wr_en, ram_rd_en);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        step();
    endtask

    task automatic test_latency();
        int lat;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hDEADBEEF;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (ram_wr_en !== EXP_WR) begin
            failures++;
            $display("FAIL lat_wr_en: got %b expected %b", ram_wr_en, EXP_WR);
        end
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected %0d", lat, LAT);
        end
        checks++;
        if (bus.out_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lat_data: got %h expected deadbeef", bus.out_data);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic fill(output int n);
        n = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = $urandom;
            #1;
            if (!bus.in_ready) break;
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_fill();
        int n;
        fill(n);
        checks++;
        if (n != 10 || count !== 5'd10 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL fill: got pushes=%0d count=%0d valid=%b expected 10 10 1", n, count, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL drain_gap: got valid=0 at beat %0d expected 1", i);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL drain_empty: got valid=%b count=%0d expected 0 0", bus.out_valid, count);
        end
    endtask

    task automatic test_stream();
        int vcyc;
        int wr0;
        int wraps0;
        vcyc = 0;
        wr0 = wr_cnt;
        wraps0 = wraps;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'(20 * i);
            #1;
            if (bus.out_valid) vcyc++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (vcyc != 40 - LAT) begin
            failures++;
            $display("FAIL stream_gaps: got %0d valid cycles expected %0d", vcyc, 40 - LAT);
        end
`ifdef RAM_FIFO_BYPASS_EN
        checks++;
        if (wr_cnt - wr0 != 0) begin
            failures++;
            $display("FAIL stream_bypass: got %0d ram writes expected 0", wr_cnt - wr0);
        end
`else
        checks++;
        if (wraps - wraps0 < 4) begin
            failures++;
            $display("FAIL stream_wrap: got %0d pointer wraps expected at least 4", wraps - wraps0);
        end
`endif
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL stream_empty: got count %0d expected 0", count);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic acc;
        bus.in_data = $urandom;
        for (int c = 0; c < 60; c++) begin
            bus.in_valid = 1'b1;
            bus.out_ready = c[0];
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) bus.in_data = $urandom;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (15) step();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL bp_drain: got count %0d expected 0", count);
        end
    endtask

    task automatic test_full_boundary();
        int n;
        int wait_c;
        fill(n);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hF00DF00D;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        wait_c = 0;
        while (!bus.in_ready && wait_c < 10) begin
            step();
            wait_c++;
        end
        checks++;
        if (wait_c >= 10) begin
            failures++;
            $display("FAIL full_reaccept: got no in_ready within %0d cycles expected accept", wait_c);
        end
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (count !== 5'd10) begin
            failures++;
            $display("FAIL full_refill: got count %0d expected 10", count);
        end
        bus.out_ready = 1'b1;
        repeat (15) step();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL full_drain: got count %0d expected 0", count);
        end
    endtask

    task automatic test_random();
        logic acc;
        bus.in_data = $urandom;
        for (int c = 0; c < 300; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) bus.in_data = $urandom;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (15) step();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL rand_drain: got count %0d expected 0", count);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = $urandom;
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        c = 0;
        #1;
        while (!ram_rd_en && c < 20) begin
            @(posedge clk);
            #2;
            c++;
        end
        checks++;
        if (c >= 20) begin
            failures++;
            $display("FAIL mid_rd_issue: got no ram_rd_en within %0d cycles expected one", c);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b count=%0d expected 0 0", bus.out_valid, count);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale: got valid=1 data=%h expected valid=0", bus.out_data);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_fill();
        test_stream();
        test_backpressure();
        test_full_boundary();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by 200000 ns expected completion");
        $fatal(1, "timeout");
    end

endmodule
